// File: rtl/car_shaft_model.sv
// Single elevator car moving along a shaft: accepts floor requests, steps between
// floors in TRAVEL_CYCLES clocks, and reports floor alignment plus arrival/abort events.
module car_shaft_model #(
    parameter int NUM_FLOORS    = 10,
    parameter int FLOOR_WIDTH   = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int RESET_FLOOR   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    input  logic [FLOOR_WIDTH-1:0] cmd_floor,
    output logic                   cmd_ready,
    input  logic                   estop,
    output logic [NUM_FLOORS-1:0]  floor_sensors,
    output logic [FLOOR_WIDTH-1:0] car_floor,
    output logic                   moving_up,
    output logic                   moving_down,
    output logic                   arrived,
    output logic                   aborted,
    output logic                   cmd_error
);

    localparam int SUB_W = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MOVE_UP   = 2'd1;
    localparam logic [1:0] S_MOVE_DOWN = 2'd2;

    localparam logic [SUB_W-1:0]       LAST_SUB    = SUB_W'(TRAVEL_CYCLES - 1);
    localparam logic [SUB_W-1:0]       SUB_ONE     = SUB_W'(1);
    localparam logic [FLOOR_WIDTH:0]   FLOOR_LIMIT = (FLOOR_WIDTH + 1)'(NUM_FLOORS);
    localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR   = FLOOR_WIDTH'(NUM_FLOORS - 1);
    localparam logic [FLOOR_WIDTH-1:0] HOME_FLOOR  = FLOOR_WIDTH'(RESET_FLOOR);
    localparam logic [FLOOR_WIDTH-1:0] FLOOR_ONE   = FLOOR_WIDTH'(1);

    logic [1:0]             state_reg,   state_next;
    logic [SUB_W-1:0]       sub_reg,     sub_next;
    logic [FLOOR_WIDTH-1:0] floor_reg,   floor_next;
    logic [FLOOR_WIDTH-1:0] target_reg,  target_next;
    logic                   stop_reg,    stop_next;
    logic [NUM_FLOORS-1:0]  sensors_reg, sensors_next;
    logic                   ready_reg,   ready_next;
    logic                   up_reg,      down_reg;
    logic                   arrived_reg, arrived_next;
    logic                   aborted_reg, aborted_next;
    logic                   error_reg,   error_next;

    always_comb begin
        state_next   = state_reg;
        sub_next     = sub_reg;
        floor_next   = floor_reg;
        target_next  = target_reg;
        stop_next    = stop_reg;
        arrived_next = 1'b0;
        aborted_next = 1'b0;
        error_next   = 1'b0;
        case (state_reg)
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (estop) begin
                    stop_next = 1'b1;
                end
                // The boundary decision is taken in the cycle the car sits level (sub==0),
                // so each floor costs exactly TRAVEL_CYCLES clocks including the last one.
                if (sub_reg == '0) begin
                    if (floor_reg == target_reg) begin
                        arrived_next = 1'b1;
                        state_next   = S_IDLE;
                        stop_next    = 1'b0;
                    end else if (stop_reg || estop) begin
                        aborted_next = 1'b1;
                        state_next   = S_IDLE;
                        stop_next    = 1'b0;
                    end else begin
                        sub_next = SUB_ONE;
                    end
                end else if (sub_reg == LAST_SUB) begin
                    sub_next = '0;
                    if (state_reg == S_MOVE_UP && floor_reg != TOP_FLOOR) begin
                        floor_next = floor_reg + FLOOR_ONE;
                    end else if (state_reg == S_MOVE_DOWN && floor_reg != '0) begin
                        floor_next = floor_reg - FLOOR_ONE;
                    end
                end else begin
                    sub_next = sub_reg + SUB_ONE;
                end
            end
            default: begin
                stop_next = 1'b0;
                if (cmd_valid && ready_reg) begin
                    if ({1'b0, cmd_floor} >= FLOOR_LIMIT) begin
                        error_next = 1'b1;
                    end else if (cmd_floor == floor_reg) begin
                        arrived_next = 1'b1;
                    end else begin
                        target_next = cmd_floor;
                        sub_next    = SUB_ONE;
                        state_next  = (cmd_floor > floor_reg) ? S_MOVE_UP : S_MOVE_DOWN;
                    end
                end
            end
        endcase
        ready_next = (state_next == S_IDLE) && !estop;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_sensor
            assign sensors_next[gi] = (sub_next == '0) && (floor_next == FLOOR_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            sub_reg     <= '0;
            floor_reg   <= HOME_FLOOR;
            target_reg  <= HOME_FLOOR;
            stop_reg    <= 1'b0;
            sensors_reg <= NUM_FLOORS'(1) << RESET_FLOOR;
            ready_reg   <= 1'b1;
            up_reg      <= 1'b0;
            down_reg    <= 1'b0;
            arrived_reg <= 1'b0;
            aborted_reg <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sub_reg     <= sub_next;
            floor_reg   <= floor_next;
            target_reg  <= target_next;
            stop_reg    <= stop_next;
            sensors_reg <= sensors_next;
            ready_reg   <= ready_next;
            up_reg      <= (state_next == S_MOVE_UP);
            down_reg    <= (state_next == S_MOVE_DOWN);
            arrived_reg <= arrived_next;
            aborted_reg <= aborted_next;
            error_reg   <= error_next;
        end
    end

    assign cmd_ready     = ready_reg;
    assign floor_sensors = sensors_reg;
    assign car_floor     = floor_reg;
    assign moving_up     = up_reg;
    assign moving_down   = down_reg;
    assign arrived       = arrived_reg;
    assign aborted       = aborted_reg;
    assign cmd_error     = error_reg;

endmodule

// File: tb/tb_car_shaft_model.sv
// Directed bench for car_shaft_model: travel timing, error/same-floor requests,
// emergency stop at and between boundaries, and reset during travel.
module tb_car_shaft_model;

    localparam int TC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [3:0] cmd_floor;
    logic       cmd_ready;
    logic       estop;
    logic [9:0] floor_sensors;
    logic [3:0] car_floor;
    logic       moving_up;
    logic       moving_down;
    logic       arrived;
    logic       aborted;
    logic       cmd_error;

    int n_checks = 0;
    int n_fails  = 0;

    car_shaft_model #(
        .NUM_FLOORS(10), .FLOOR_WIDTH(4), .TRAVEL_CYCLES(TC), .RESET_FLOOR(0)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_floor(cmd_floor),
        .cmd_ready(cmd_ready), .estop(estop), .floor_sensors(floor_sensors),
        .car_floor(car_floor), .moving_up(moving_up), .moving_down(moving_down),
        .arrived(arrived), .aborted(aborted), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request dest from IDLE and wait the travel time, expecting arrived only at the end.
    task automatic move(input logic [3:0] dest, input int n);
        cmd_floor = dest;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= n * TC; k++) begin
            tick();
            chk("arrive_wait", 32'(arrived), 32'(k == n * TC));
        end
        chk("move_floor", 32'(car_floor), 32'(dest));
        $display("move to %0d done at t=%0t", dest, $time);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_floor = '0; estop = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_sensors", 32'(floor_sensors), 32'h001);
        chk("rst_floor", 32'(car_floor), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_motion", 32'({moving_up, moving_down}), 0);
        chk("rst_pulses", 32'({arrived, aborted, cmd_error}), 0);
        $display("reset checked");

        // 0 -> 3: sensors step through floors 1,2,3 at 8-cycle spacing
        cmd_floor = 4'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("acc_ready", 32'(cmd_ready), 0);
        chk("acc_up", 32'(moving_up), 1);
        chk("acc_sensors", 32'(floor_sensors), 0);
        for (int k = 1; k <= 3 * TC; k++) begin
            logic [9:0] exp_s;
            exp_s = 10'h000;
            if (k == 7) exp_s = 10'h002;
            if (k == 15) exp_s = 10'h004;
            if (k >= 23) exp_s = 10'h008;
            tick();
            chk("up3_sensors", 32'(floor_sensors), 32'(exp_s));
            chk("up3_arrived", 32'(arrived), 32'(k == 3 * TC));
            chk("up3_moving", 32'(moving_up), 32'(k < 3 * TC));
            chk("up3_down", 32'(moving_down), 0);
        end
        chk("up3_floor", 32'(car_floor), 3);
        chk("up3_ready", 32'(cmd_ready), 1);
        $display("trip 0->3 checked");

        move(4'd5, 2);
        // 5 -> 2 downward
        cmd_floor = 4'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("dn_moving", 32'(moving_down), 1);
        chk("dn_up", 32'(moving_up), 0);
        for (int k = 1; k <= 3 * TC; k++) begin
            tick();
            chk("dn_arrived", 32'(arrived), 32'(k == 3 * TC));
        end
        chk("dn_floor", 32'(car_floor), 2);
        chk("dn_ready", 32'(cmd_ready), 1);
        chk("dn_flag", 32'(moving_down), 0);
        $display("trip 5->2 checked");

        // Out-of-range request
        cmd_floor = 4'd12; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("err_pulse", 32'(cmd_error), 1);
        chk("err_sensors", 32'(floor_sensors), 32'h004);
        chk("err_floor", 32'(car_floor), 2);
        chk("err_ready", 32'(cmd_ready), 1);
        chk("err_motion", 32'({moving_up, moving_down}), 0);
        tick();
        chk("err_single", 32'(cmd_error), 0);
        $display("bad request checked");

        // Same-floor requests back to back, then a bad one
        cmd_floor = 4'd2; cmd_valid = 1'b1;
        tick();
        chk("same_arr1", 32'(arrived), 1);
        chk("same_motion", 32'({moving_up, moving_down}), 0);
        chk("same_ready", 32'(cmd_ready), 1);
        tick();
        chk("same_arr2", 32'(arrived), 1);
        cmd_floor = 4'd10;
        tick();
        chk("b2b_err", 32'(cmd_error), 1);
        chk("b2b_arr", 32'(arrived), 0);
        cmd_valid = 1'b0;
        tick();
        chk("same_idle", 32'({arrived, cmd_error}), 0);
        $display("same-floor requests checked");

        // estop high on the boundary cycle that is also the target: arrival wins
        cmd_floor = 4'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k < TC; k++) tick();
        chk("es_tgt_sens", 32'(floor_sensors), 32'h008);
        estop = 1'b1;
        tick();
        chk("es_tgt_arr", 32'(arrived), 1);
        chk("es_tgt_abort", 32'(aborted), 0);
        chk("es_idle_ready", 32'(cmd_ready), 0);
        tick();
        chk("es_hold_ready", 32'(cmd_ready), 0);
        estop = 1'b0;
        tick();
        chk("es_rel_ready", 32'(cmd_ready), 1);
        $display("estop at target checked");

        move(4'd0, 3);
        // 0 -> 6 with estop pulse sampled at sub=3 between floors 1 and 2
        cmd_floor = 4'd6; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        estop = 1'b1;
        tick();
        estop = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("es_coast", 32'(aborted), 0);
        end
        chk("es_at2_sens", 32'(floor_sensors), 32'h004);
        chk("es_at2_floor", 32'(car_floor), 2);
        tick();
        chk("es_aborted", 32'(aborted), 1);
        chk("es_no_arr", 32'(arrived), 0);
        chk("es_stopped", 32'({moving_up, moving_down}), 0);
        chk("es_ready", 32'(cmd_ready), 1);
        tick();
        chk("es_single", 32'(aborted), 0);
        $display("estop mid-travel checked");

        // Reset between floors 4 and 5
        cmd_floor = 4'd5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 18; k++) tick();
        chk("pre_rst_sens", 32'(floor_sensors), 0);
        rst = 1'b1; cmd_valid = 1'b1;
        tick();
        rst = 1'b0; cmd_valid = 1'b0;
        chk("mrst_floor", 32'(car_floor), 0);
        chk("mrst_sens", 32'(floor_sensors), 32'h001);
        chk("mrst_ready", 32'(cmd_ready), 1);
        chk("mrst_motion", 32'({moving_up, moving_down}), 0);
        chk("mrst_pulses", 32'({arrived, aborted, cmd_error}), 0);
        // Reset on an edge that would otherwise accept a request
        cmd_floor = 4'd4; cmd_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; cmd_valid = 1'b0;
        tick();
        chk("rst_discard", 32'({moving_up, moving_down}), 0);
        chk("rst_disc_sens", 32'(floor_sensors), 32'h001);
        $display("reset during travel checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
